// File: rtl/ir_sequence_unit.sv
// Instruction register, sequence counter and start/stop flip-flop for the basic computer control unit.
// Optional SC_OVF_TRAP_EN: an SC wrap also halts the machine (clears s_run).
module ir_sequence_unit #(
    parameter int WORD_W = 16,
    parameter int SC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] bus_in,
    input  logic              ir_ld,
    input  logic              sc_inr,
    input  logic              sc_clr,
    input  logic              start,
    input  logic              hlt,
    output logic [WORD_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic              i_bit,
    output logic [11:0]       addr,
    output logic [SC_W-1:0]   sc,
    output logic              s_run,
    output logic              op_valid,
    output logic              sc_ovf
);

    logic sc_step;
    logic sc_wrap;

    // Increment is gated by the pre-edge s_run, so an hlt on the same edge still lets SC advance once.
    assign sc_step = !sc_clr && sc_inr && s_run;
    assign sc_wrap = sc_step && (sc == {SC_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            sc       <= '0;
            s_run    <= 1'b0;
            op_valid <= 1'b0;
            sc_ovf   <= 1'b0;
        end else begin
            if (ir_ld)
                ir <= bus_in;

            if (sc_clr)
                sc <= '0;
            else if (sc_step)
                sc <= sc + 1'b1;

            if (sc_wrap)
                sc_ovf <= 1'b1;

`ifdef SC_OVF_TRAP_EN
            if (hlt || sc_wrap)
                s_run <= 1'b0;
            else if (start)
                s_run <= 1'b1;
`else
            if (hlt)
                s_run <= 1'b0;
            else if (start)
                s_run <= 1'b1;
`endif

            // A load on the clearing edge wins: the new instruction survives.
            if (ir_ld)
                op_valid <= 1'b1;
            else if (sc_clr)
                op_valid <= 1'b0;
        end
    end

    assign opcode = ir[14:12];
    assign i_bit  = ir[15];
    assign addr   = ir[11:0];

endmodule

// File: tb/tb_ir_sequence_unit.sv
// Bench for ir_sequence_unit: directed scenarios plus random stimulus against a cycle-level reference model.
module tb_ir_sequence_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus_in = '0;
    logic        ir_ld = 1'b0, sc_inr = 1'b0, sc_clr = 1'b0, start = 1'b0, hlt = 1'b0;
    logic [15:0] ir;
    logic [2:0]  opcode;
    logic        i_bit;
    logic [11:0] addr;
    logic [3:0]  sc;
    logic        s_run, op_valid, sc_ovf;

    int total = 0;
    int bad   = 0;

    // reference state
    int m_ir, m_sc;
    bit m_run, m_valid, m_ovf;

    ir_sequence_unit #(.WORD_W(16), .SC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ir_ld(ir_ld), .sc_inr(sc_inr),
        .sc_clr(sc_clr), .start(start), .hlt(hlt), .ir(ir), .opcode(opcode),
        .i_bit(i_bit), .addr(addr), .sc(sc), .s_run(s_run), .op_valid(op_valid),
        .sc_ovf(sc_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ir = 0; m_sc = 0; m_run = 0; m_valid = 0; m_ovf = 0;
    endtask

    task automatic check_all();
        chk("ir",       32'(ir),       32'(m_ir));
        chk("opcode",   32'(opcode),   32'((m_ir / 4096) % 8));
        chk("i_bit",    32'(i_bit),    32'(m_ir / 32768));
        chk("addr",     32'(addr),     32'(m_ir % 4096));
        chk("sc",       32'(sc),       32'(m_sc));
        chk("s_run",    32'(s_run),    32'(m_run));
        chk("op_valid", 32'(op_valid), 32'(m_valid));
        chk("sc_ovf",   32'(sc_ovf),   32'(m_ovf));
    endtask

    // One clock: model applies the edge rules from pre-edge state, then outputs are compared.
    task automatic cyc();
        int  nsc;
        bit  wrap, nrun, nvalid;
        @(posedge clk);
        nsc  = m_sc;
        wrap = 0;
        if (sc_clr) nsc = 0;
        else if (sc_inr && m_run) begin
            nsc  = (m_sc + 1) % 16;
            wrap = (nsc == 0);
        end
        nrun = m_run;
        if (hlt) nrun = 0;
        else if (start) nrun = 1;
`ifdef SC_OVF_TRAP_EN
        if (wrap) nrun = 0;
`endif
        nvalid = m_valid;
        if (ir_ld) nvalid = 1;
        else if (sc_clr) nvalid = 0;
        if (ir_ld) m_ir = int'(bus_in);
        m_sc = nsc; m_run = nrun; m_valid = nvalid;
        if (wrap) m_ovf = 1;
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        ir_ld = 0; sc_inr = 0; sc_clr = 0; start = 0; hlt = 0;
    endtask

    task automatic mid_cycle_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rst_ir", 32'(ir), 32'h0);
        check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();

        // load something, then reset asynchronously mid-cycle
        start = 1; bus_in = 16'hFFFF; ir_ld = 1; cyc();
        idle_inputs(); sc_inr = 1; cyc();
        mid_cycle_reset();
        idle_inputs(); sc_inr = 1;
        repeat (3) cyc();
        chk("idle_sc", 32'(sc), 32'h0);

        // fetch load
        idle_inputs(); start = 1; cyc();
        start = 0; bus_in = 16'hB123; ir_ld = 1; cyc();
        ir_ld = 0;
        chk("fetch_ir", 32'(ir), 32'hB123);
        chk("fetch_i", 32'(i_bit), 32'h1);
        chk("fetch_op", 32'(opcode), 32'h3);
        chk("fetch_addr", 32'(addr), 32'h123);
        chk("fetch_valid", 32'(op_valid), 32'h1);

        // count and clear
        sc_inr = 1; repeat (5) cyc();
        chk("count5", 32'(sc), 32'h5);
        sc_clr = 1; cyc(); sc_clr = 0;
        chk("clr_sc", 32'(sc), 32'h0);
        chk("clr_valid", 32'(op_valid), 32'h0);

        // wrap
        repeat (16) cyc();
        chk("wrap_sc", 32'(sc), 32'h0);
        chk("wrap_ovf", 32'(sc_ovf), 32'h1);
`ifdef SC_OVF_TRAP_EN
        chk("trap_run", 32'(s_run), 32'h0);
        cyc();
        chk("trap_hold", 32'(sc), 32'h0);
`else
        chk("wrap_run", 32'(s_run), 32'h1);
`endif

        // halt priority and hlt with increment
        idle_inputs(); start = 1; hlt = 1; cyc();
        chk("hlt_prio", 32'(s_run), 32'h0);
        hlt = 0; cyc(); start = 0;
        sc_clr = 1; cyc(); sc_clr = 0;
        sc_inr = 1; repeat (3) cyc();
        chk("pre_hlt", 32'(sc), 32'h3);
        hlt = 1; cyc(); hlt = 0;
        chk("hlt_inc", 32'(sc), 32'h4);
        chk("hlt_run", 32'(s_run), 32'h0);
        cyc();
        chk("hlt_frozen", 32'(sc), 32'h4);

        // load and clear on the same edge
        idle_inputs(); bus_in = 16'h7800; ir_ld = 1; sc_clr = 1; cyc();
        idle_inputs();
        chk("ldclr_valid", 32'(op_valid), 32'h1);
        chk("ldclr_op", 32'(opcode), 32'h7);
        chk("ldclr_i", 32'(i_bit), 32'h0);
        chk("ldclr_sc", 32'(sc), 32'h0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            bus_in = 16'($urandom);
            ir_ld  = ($urandom_range(0, 99) < 20);
            sc_inr = ($urandom_range(0, 99) < 75);
            sc_clr = ($urandom_range(0, 99) < 4);
            start  = ($urandom_range(0, 99) < 12);
            hlt    = ($urandom_range(0, 99) < 4);
            cyc();
            if (n == 300) mid_cycle_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
